// File: rtl/shift_sweep_ctrl.sv
// shift_sweep_ctrl: sweeps a barrel shifter through every shift amount and hands each result downstream; optional self-check under SHIFT_SWEEP_SELFCHECK_EN
module shift_sweep_ctrl #(
  parameter int DW = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] din_i,
  input  logic          a_l_i,
  input  logic          l_r_i,
  output logic [DW-1:0] sh_din_o,
  output logic [SW-1:0] sh_shamt_o,
  output logic          sh_a_l_o,
  output logic          sh_l_r_o,
  input  logic [DW-1:0] sh_dout_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [DW-1:0] res_data_o,
  output logic [SW-1:0] res_shamt_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD, DONE} state_t;
  state_t        state_q;
  logic [DW-1:0] sh_din_q, res_data_q;
  logic [SW-1:0] sh_shamt_q, res_shamt_q;
  logic          sh_a_l_q, sh_l_r_q, res_valid_q, busy_q, done_q;
  // sweep sequencer: latch on start, capture in DRIVE, wait for handshake in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_din_q    <= '0;
      sh_shamt_q  <= '0;
      sh_a_l_q    <= 1'b0;
      sh_l_r_q    <= 1'b0;
      res_data_q  <= '0;
      res_shamt_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          sh_din_q   <= din_i;
          sh_a_l_q   <= a_l_i;
          sh_l_r_q   <= l_r_i;
          sh_shamt_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= DRIVE;
        end
        DRIVE: begin
          res_data_q  <= sh_dout_i;
          res_shamt_q <= sh_shamt_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: if (res_ready_i) begin
          res_valid_q <= 1'b0;
          if (sh_shamt_q == SW'(DW-1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            sh_shamt_q <= sh_shamt_q + 1'b1;
            state_q    <= DRIVE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SHIFT_SWEEP_SELFCHECK_EN
  logic [DW-1:0] asr_w, exp_w;
  logic          err_q;
  // reference shift; the arithmetic form is kept separate so the sign survives
  always_comb begin
    asr_w = $signed(sh_din_q) >>> sh_shamt_q;
    exp_w = sh_l_r_q ? (sh_a_l_q ? sh_din_q >> sh_shamt_q : asr_w) : sh_din_q << sh_shamt_q;
  end
  // sticky mismatch flag, cleared by reset or a new sweep
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == IDLE && start_i) err_q <= 1'b0;
    else if (state_q == DRIVE && exp_w != sh_dout_i) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
  assign sh_din_o    = sh_din_q;
  assign sh_shamt_o  = sh_shamt_q;
  assign sh_a_l_o    = sh_a_l_q;
  assign sh_l_r_o    = sh_l_r_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_shamt_o = res_shamt_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
endmodule

// File: doc/shift_sweep_ctrl.md
# shift_sweep_ctrl

Sequencer that sits directly upstream of `barrel_shifter` and also consumes its output. On a start pulse it latches one operand and shift mode, then steps the shift amount from 0 to DW-1. For each step it drives the shifter, captures the result, and offers it downstream over a valid/ready handshake. It is used for board bring-up and for regression sweeps of the shifter.

## Interface
Parameters:
- `DW`, 8, data width; must be a power of two, at least 2.
- `SW`, 3, shift-amount width; must equal clog2(DW).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin a sweep; sampled only in IDLE.
- `din_i`  in  DW  operand; latched on an accepted start.
- `a_l_i`  in  1  mode: 0 = arithmetic, 1 = logical; latched on start.
- `l_r_i`  in  1  direction: 0 = left, 1 = right; latched on start.
- `sh_din_o`  out  DW  operand driven to the shifter's `Din`.
- `sh_shamt_o`  out  SW  current shift amount, driven to `Shamt`.
- `sh_a_l_o`  out  1  driven to `A_L`.
- `sh_l_r_o`  out  1  driven to `L_R`.
- `sh_dout_i`  in  DW  shifter result (`Dout`), combinational from the `sh_*` outputs.
- `res_valid_o`  out  1  a captured result is available.
- `res_ready_i`  in  1  downstream accepts the result.
- `res_data_o`  out  DW  captured result.
- `res_shamt_o`  out  SW  shift amount that produced `res_data_o`.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at the end of a sweep.
- `err_o`  out  1  sticky self-check mismatch flag (see Configuration).

## Operation
- State machine: IDLE, DRIVE, HOLD, DONE.
- IDLE:
  - On `start_i`=1: latch `din_i`, `a_l_i` and `l_r_i` into the `sh_*` registers, set `sh_shamt_o`=0, clear `err_o`, go to DRIVE.
- DRIVE (one cycle):
  - Capture `sh_dout_i` into `res_data_o` and `sh_shamt_o` into `res_shamt_o`.
  - Set `res_valid_o`=1 and go to HOLD.
- HOLD:
  - Outputs are held stable while `res_ready_i`=0.
  - On `res_valid_o`&&`res_ready_i`:
    - Clear `res_valid_o`.
    - If `sh_shamt_o`==DW-1, go to DONE.
    - Otherwise increment `sh_shamt_o` and go to DRIVE.
- DONE (one cycle): `done_o`=1, then go to IDLE.
- `start_i` is ignored in DRIVE, HOLD and DONE; no queueing.
- `din_i`, `a_l_i` and `l_r_i` are ignored except at an accepted start.
- `sh_din_o`, `sh_a_l_o` and `sh_l_r_o` stay constant for the whole sweep and keep their values in IDLE afterwards.
- `sh_shamt_o` never wraps: the sweep terminates at DW-1.
- Expected shifter semantics, used by the self-check:
  - Left shifts fill with 0 in both modes.
  - Logical right shifts fill with 0.
  - Arithmetic right shifts fill with `sh_din_o[DW-1]`.

## Timing
- Reset: on a `rst` edge every output is 0 and the state is IDLE. `rst` overrides everything, including in the middle of a sweep. No partial result or `done_o` is emitted after reset.
- Latency:
  - `start_i` sampled at edge k puts the state in DRIVE during cycle k+1.
  - The first `res_valid_o`=1 appears after edge k+2.
- Throughput: with `res_ready_i` held at 1, one result every 2 cycles. A full sweep is 2·DW cycles plus 1 cycle of DONE (8-bit: 17 cycles after the start edge).
- `done_o` is high for exactly one cycle, on the cycle after the final handshake edge. `busy_o` falls on the same edge that `done_o` falls.
- The shifter path is combinational. `sh_*` are register outputs, so `sh_dout_i` must settle within one cycle.
- `res_data_o` and `res_shamt_o` change only on the DRIVE capture edge and never while `res_valid_o`=1.

## Configuration
- Macro: `SHIFT_SWEEP_SELFCHECK_EN`.
- Defined:
  - In DRIVE, an internal behavioural shift of `sh_din_o` by `sh_shamt_o` under the latched mode is compared with `sh_dout_i`.
  - On a mismatch, `err_o` is set at the capture edge.
  - `err_o` stays set until `rst` or the next accepted start.
- Undefined: no comparator logic; `err_o` is tied to 0.
- Ports are identical in both builds.

## Test plan
- `din_i`=0x96, logical right, `res_ready_i`=1 → results 96,4B,25,12,09,04,02,01 with shamt 0..7; `done_o` 17 cycles after start; `err_o`=0.
- `din_i`=0x96, arithmetic right → 96,CB,E5,F2,F9,FC,FE,FF.
- `din_i`=0x81, arithmetic left → 81,02,04,08,10,20,40,80.
- Backpressure: drop `res_ready_i` for 5 cycles at shamt 3 → `res_data_o`=0x12 and `sh_shamt_o`=3 held; no result skipped or repeated. Also pulse `start_i` while busy → ignored.
- `rst` in HOLD at shamt 4 → next cycle all outputs 0 and `busy_o`=0. A new start then sweeps from shamt 0.
- With the macro defined, the bench corrupts `sh_dout_i` at shamt 2 → `err_o`=1 from the capture edge, sticky through `done_o`, cleared by the next start.
